// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: operation codes, arbiter FSM states
// and the requester-index width helper.
package alu_pkg;

    localparam logic [3:0] OP_SUMA  = 4'd0;
    localparam logic [3:0] OP_RESTA = 4'd1;
    localparam logic [3:0] OP_MULT  = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_MOD   = 4'd4;
    localparam logic [3:0] OP_AND   = 4'd5;
    localparam logic [3:0] OP_OR    = 4'd6;
    localparam logic [3:0] OP_XOR   = 4'd7;
    localparam logic [3:0] OP_SHL   = 4'd8;
    localparam logic [3:0] OP_SHR   = 4'd9;

    typedef enum logic [1:0] {
        LIBRE    = 2'd0,
        EJECUTA  = 2'd1,
        RESPONDE = 2'd2
    } estado_arbitro_t;

    function automatic int anchoId(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arbitro_alu_alu.sv
// Combinational ALU shared by all requesters: result plus N/Z/C/V flags.
// C is carry-out (suma), borrow (resta) or high-half-nonzero (mult).
module alu_basica
    import alu_pkg::*;
#(
    parameter int ANCHO = 3
) (
    input  logic [ANCHO:0] a,
    input  logic [ANCHO:0] b,
    input  logic [3:0]     sel,
    output logic [ANCHO:0] res,
    output logic           n,
    output logic           z,
    output logic           c,
    output logic           v
);

    localparam int W = ANCHO + 1;

    function automatic logic desborde(input logic signed [W-1:0] x,
                                      input logic signed [W-1:0] y,
                                      input logic signed [W-1:0] r,
                                      input logic esResta);
        logic mismoSigno;
        mismoSigno = ((x < 0) == (y < 0));
        return (esResta ? !mismoSigno : mismoSigno) && ((r < 0) != (x < 0));
    endfunction

    logic [W:0]     ext;
    logic [2*W-1:0] prod;

    always_comb begin
        res  = '0;
        c    = 1'b0;
        v    = 1'b0;
        ext  = '0;
        prod = '0;
        case (sel)
            OP_SUMA: begin
                ext = {1'b0, a} + {1'b0, b};
                res = ext[W-1:0];
                c   = ext[W];
                v   = desborde(a, b, ext[W-1:0], 1'b0);
            end
            OP_RESTA: begin
                ext = {1'b0, a} - {1'b0, b};
                res = ext[W-1:0];
                c   = ext[W];
                v   = desborde(a, b, ext[W-1:0], 1'b1);
            end
            OP_MULT: begin
                prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                res  = prod[W-1:0];
                c    = |prod[2*W-1:W];
            end
            // Divide by zero yields all ones, modulo by zero yields the dividend
            OP_DIV:  res = (b == '0) ? '1 : a / b;
            OP_MOD:  res = (b == '0) ? a : a % b;
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_SHL:  res = a << b;
            OP_SHR:  res = a >> b;
            default: res = '0;
        endcase
    end

    assign n = res[W-1];
    assign z = (res == '0);

endmodule

// File: rtl/arbitro_alu_selector.sv
// Round-robin selector: first active request found at or after puntero,
// wrapping modulo NUM_SOL.
module selector_round_robin
    import alu_pkg::*;
#(
    parameter int NUM_SOL = 2,
    parameter int ID_W    = anchoId(NUM_SOL)
) (
    input  logic [NUM_SOL-1:0] solicitud,
    input  logic [ID_W-1:0]    puntero,
    output logic [NUM_SOL-1:0] concesion,
    output logic [ID_W-1:0]    ganador
);

    logic encontrado;
    int   cand;

    always_comb begin
        concesion  = '0;
        ganador    = '0;
        encontrado = 1'b0;
        cand       = 0;
        for (int k = 0; k < NUM_SOL; k++) begin
            cand = (int'(puntero) + k) % NUM_SOL;
            if (!encontrado && solicitud[ID_W'(cand)]) begin
                encontrado              = 1'b1;
                concesion[ID_W'(cand)] = 1'b1;
                ganador                 = ID_W'(cand);
            end
        end
    end

endmodule

// File: rtl/arbitro_alu.sv
// Round-robin arbiter/sequencer sharing one ALU among NUM_SOL requesters.
// Optional ARBITRO_ALU_DIV_CERO_EN: flag divide/modulo by zero as an error response.
module arbitro_alu
    import alu_pkg::*;
#(
    parameter int ANCHO   = 3,
    parameter int NUM_SOL = 2,
    parameter int ID_W    = anchoId(NUM_SOL)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_SOL-1:0]         solicitud,
    input  logic [NUM_SOL*(ANCHO+1)-1:0] operandosA,
    input  logic [NUM_SOL*(ANCHO+1)-1:0] operandosB,
    input  logic [NUM_SOL*4-1:0]       selecciones,
    output logic [NUM_SOL-1:0]         concesion,
    output logic [ANCHO:0]             resultado,
    output logic                       bandera_n,
    output logic                       bandera_z,
    output logic                       bandera_c,
    output logic                       bandera_v,
    output logic [ID_W-1:0]            id_respuesta,
    output logic                       error_div_cero,
    output logic                       respuesta_valida,
    input  logic                       respuesta_lista,
    output logic                       ocupado
);

    localparam int W = ANCHO + 1;

    estado_arbitro_t estado;
    logic [ID_W-1:0]    puntero;
    logic [NUM_SOL-1:0] grantRr;
    logic [ID_W-1:0]    ganador;
    logic [W-1:0]       opASel, opBSel;
    logic [3:0]         selSel;

    logic [W-1:0]       opA_p1, opB_p1;
    logic [3:0]         sel_p1;
    logic [ID_W-1:0]    id_p1;

    logic [W-1:0]       aluRes;
    logic               aluN, aluZ, aluC, aluV;
    logic               divCero;

    selector_round_robin #(.NUM_SOL(NUM_SOL), .ID_W(ID_W)) uSelector (
        .solicitud (solicitud),
        .puntero   (puntero),
        .concesion (grantRr),
        .ganador   (ganador)
    );

    always_comb begin
        opASel = '0;
        opBSel = '0;
        selSel = '0;
        for (int j = 0; j < NUM_SOL; j++) begin
            if (ganador == ID_W'(j)) begin
                opASel = operandosA[j*W +: W];
                opBSel = operandosB[j*W +: W];
                selSel = selecciones[j*4 +: 4];
            end
        end
    end

    // No grant is visible while reset is held, even though the state reads LIBRE
    assign concesion = (rst_n && estado == LIBRE) ? grantRr : '0;

    // Stage p1: winner's operands latched at the grant edge
    always_ff @(posedge clk) begin
        if (estado == LIBRE && |solicitud) begin
            opA_p1 <= opASel;
            opB_p1 <= opBSel;
            sel_p1 <= selSel;
            id_p1  <= ganador;
        end
    end

    alu_basica #(.ANCHO(ANCHO)) uAlu (
        .a   (opA_p1),
        .b   (opB_p1),
        .sel (sel_p1),
        .res (aluRes),
        .n   (aluN),
        .z   (aluZ),
        .c   (aluC),
        .v   (aluV)
    );

`ifdef ARBITRO_ALU_DIV_CERO_EN
    assign divCero = ((sel_p1 == OP_DIV) || (sel_p1 == OP_MOD)) && (opB_p1 == '0);
`else
    assign divCero = 1'b0;
`endif

    // Stage p2: registered response, held until the consumer accepts it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado           <= LIBRE;
            puntero          <= '0;
            ocupado          <= 1'b0;
            respuesta_valida <= 1'b0;
            resultado        <= '0;
            bandera_n        <= 1'b0;
            bandera_z        <= 1'b0;
            bandera_c        <= 1'b0;
            bandera_v        <= 1'b0;
            id_respuesta     <= '0;
            error_div_cero   <= 1'b0;
        end else begin
            case (estado)
                LIBRE: begin
                    if (|solicitud) begin
                        estado  <= EJECUTA;
                        ocupado <= 1'b1;
                    end
                end
                EJECUTA: begin
                    if (divCero) begin
                        resultado <= '0;
                        bandera_n <= 1'b0;
                        bandera_z <= 1'b0;
                        bandera_c <= 1'b0;
                        bandera_v <= 1'b0;
                    end else begin
                        resultado <= aluRes;
                        bandera_n <= aluN;
                        bandera_z <= aluZ;
                        bandera_c <= aluC;
                        bandera_v <= aluV;
                    end
                    error_div_cero   <= divCero;
                    id_respuesta     <= id_p1;
                    respuesta_valida <= 1'b1;
                    estado           <= RESPONDE;
                end
                RESPONDE: begin
                    if (respuesta_valida && respuesta_lista) begin
                        respuesta_valida <= 1'b0;
                        puntero <= (id_p1 == ID_W'(NUM_SOL - 1)) ? '0 : id_p1 + ID_W'(1);
                        estado  <= LIBRE;
                        ocupado <= 1'b0;
                    end
                end
                default: estado <= LIBRE;
            endcase
        end
    end

endmodule

// File: tb/tb_arbitro_alu.sv
// Self-checking bench for arbitro_alu (ANCHO=3, NUM_SOL=2): vector table,
// randomized traffic against a transaction-level model, and corner sequences.
module tb_arbitro_alu;

    localparam int N = 2;
    localparam int W = 4;

    typedef struct packed {
        logic [3:0] res;
        logic       n;
        logic       z;
        logic       c;
        logic       v;
        logic       err;
    } resp_t;

    typedef struct {
        int    idx;
        int    a;
        int    b;
        int    op;
        resp_t esp;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic [N-1:0]   solicitud = '0;
    logic [N*W-1:0] operandosA = '0;
    logic [N*W-1:0] operandosB = '0;
    logic [N*4-1:0] selecciones = '0;
    logic [N-1:0]   concesion;
    logic [3:0]     resultado;
    logic           bandera_n, bandera_z, bandera_c, bandera_v;
    logic [0:0]     id_respuesta;
    logic           error_div_cero, respuesta_valida, ocupado;
    logic           respuesta_lista = 1'b0;

    int   checks = 0;
    int   errors = 0;
    int   ptrModel = 0;
    logic pend[N];
    logic [3:0] pa[N], pb[N], pop[N];
    vec_t tabla[18];

    always #5 clk = ~clk;

    arbitro_alu #(.ANCHO(3), .NUM_SOL(N)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .solicitud        (solicitud),
        .operandosA       (operandosA),
        .operandosB       (operandosB),
        .selecciones      (selecciones),
        .concesion        (concesion),
        .resultado        (resultado),
        .bandera_n        (bandera_n),
        .bandera_z        (bandera_z),
        .bandera_c        (bandera_c),
        .bandera_v        (bandera_v),
        .id_respuesta     (id_respuesta),
        .error_div_cero   (error_div_cero),
        .respuesta_valida (respuesta_valida),
        .respuesta_lista  (respuesta_lista),
        .ocupado          (ocupado)
    );

    function automatic resp_t mk(input int r, input int n, input int z,
                                 input int c, input int v, input int e);
        resp_t x;
        x.res = r[3:0];
        x.n   = n[0];
        x.z   = z[0];
        x.c   = c[0];
        x.v   = v[0];
        x.err = e[0];
        return x;
    endfunction

    // Reference model: 4-bit arithmetic from plain integers and signed ranges
    function automatic resp_t refModel(input int a, input int b, input int op);
        resp_t r;
        int val, sa, sb, s;
        r   = '0;
        val = 0;
        sa  = (a >= 8) ? a - 16 : a;
        sb  = (b >= 8) ? b - 16 : b;
        case (op)
            0: begin val = a + b; r.c = (val > 15); s = sa + sb; r.v = (s > 7 || s < -8); end
            1: begin val = a - b; r.c = (a < b);    s = sa - sb; r.v = (s > 7 || s < -8); end
            2: begin val = a * b; r.c = (val > 15); end
            3: val = (b == 0) ? 15 : a / b;
            4: val = (b == 0) ? a : a % b;
            5: val = a & b;
            6: val = a | b;
            7: val = a ^ b;
            8: val = (b >= 4) ? 0 : a * (1 << b);
            9: val = (b >= 4) ? 0 : a / (1 << b);
            default: val = 0;
        endcase
        r.res = val[3:0];
        r.n   = r.res[3];
        r.z   = (r.res == 4'd0);
`ifdef ARBITRO_ALU_DIV_CERO_EN
        if ((op == 3 || op == 4) && b == 0) begin
            r     = '0;
            r.err = 1'b1;
        end
`endif
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] esp);
        checks++;
        if (act !== esp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, esp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            solicitud[i]          = pend[i];
            operandosA[i*W +: W]  = pa[i];
            operandosB[i*W +: W]  = pb[i];
            selecciones[i*4 +: 4] = pop[i];
        end
    endtask

    function automatic resp_t leer();
        return {resultado, bandera_n, bandera_z, bandera_c, bandera_v, error_div_cero};
    endfunction

    task automatic aplicarReset();
        rst_n = 1'b0;
        respuesta_lista = 1'b0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0; pa[i] = '0; pb[i] = '0; pop[i] = '0;
        end
        drive();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ptrModel = 0;
    endtask

    // One full transaction from the current LIBRE cycle; called at a negedge
    task automatic servicio(input int stall, output int w, output resp_t got);
        int t;
        logic [0:0] idPrim;
        w = -1;
        for (int k = 0; k < N; k++)
            if (w < 0 && pend[(ptrModel + k) % N]) w = (ptrModel + k) % N;
        drive();
        #1;
        t = 0;
        while (concesion == 0 && t < 10) begin
            @(negedge clk); drive(); #1; t++;
        end
        chk("concesion", 32'(concesion), 32'(1 << w));
        @(negedge clk);
        pend[w] = 1'b0;
        drive();
        #1;
        chk("concesion en ejecucion", 32'(concesion), 32'(0));
        chk("ocupado en ejecucion", 32'(ocupado), 32'(1));
        @(negedge clk);
        chk("latencia valida", 32'(respuesta_valida), 32'(1));
        got    = leer();
        idPrim = id_respuesta;
        chk("id_respuesta", 32'(id_respuesta), 32'(w));
        respuesta_lista = (stall == 0);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            #1;
            chk("espera valida", 32'(respuesta_valida), 32'(1));
            chk("espera datos", 32'(leer()), 32'(got));
            chk("espera id", 32'(id_respuesta), 32'(idPrim));
            chk("espera concesion", 32'(concesion), 32'(0));
            chk("espera ocupado", 32'(ocupado), 32'(1));
            if (s == stall - 1) respuesta_lista = 1'b1;
        end
        @(negedge clk);
        respuesta_lista = 1'b0;
        #1;
        chk("valida baja tras aceptar", 32'(respuesta_valida), 32'(0));
        ptrModel = (w + 1) % N;
    endtask

    initial begin
        int    w, ciclos[$], grants[$];
        resp_t got, esp;
        logic  alguno;

        tabla[0]  = '{0, 3, 4, 0,   mk(7, 0, 0, 0, 0, 0)};
        tabla[1]  = '{1, 5, 5, 1,   mk(0, 0, 1, 0, 0, 0)};
`ifdef ARBITRO_ALU_DIV_CERO_EN
        tabla[2]  = '{0, 9, 0, 3,   mk(0, 0, 0, 0, 0, 1)};
        tabla[17] = '{1, 7, 0, 4,   mk(0, 0, 0, 0, 0, 1)};
`else
        tabla[2]  = '{0, 9, 0, 3,   mk(15, 1, 0, 0, 0, 0)};
        tabla[17] = '{1, 7, 0, 4,   mk(7, 0, 0, 0, 0, 0)};
`endif
        tabla[3]  = '{1, 7, 1, 0,   mk(8, 1, 0, 0, 1, 0)};
        tabla[4]  = '{0, 15, 1, 0,  mk(0, 0, 1, 1, 0, 0)};
        tabla[5]  = '{1, 2, 3, 1,   mk(15, 1, 0, 1, 0, 0)};
        tabla[6]  = '{0, 8, 1, 1,   mk(7, 0, 0, 0, 1, 0)};
        tabla[7]  = '{1, 5, 3, 2,   mk(15, 1, 0, 0, 0, 0)};
        tabla[8]  = '{0, 6, 3, 2,   mk(2, 0, 0, 1, 0, 0)};
        tabla[9]  = '{1, 13, 4, 3,  mk(3, 0, 0, 0, 0, 0)};
        tabla[10] = '{0, 13, 4, 4,  mk(1, 0, 0, 0, 0, 0)};
        tabla[11] = '{1, 12, 10, 5, mk(8, 1, 0, 0, 0, 0)};
        tabla[12] = '{0, 12, 10, 6, mk(14, 1, 0, 0, 0, 0)};
        tabla[13] = '{1, 12, 10, 7, mk(6, 0, 0, 0, 0, 0)};
        tabla[14] = '{0, 3, 2, 8,   mk(12, 1, 0, 0, 0, 0)};
        tabla[15] = '{1, 12, 3, 9,  mk(1, 0, 0, 0, 0, 0)};
        tabla[16] = '{0, 9, 9, 12,  mk(0, 0, 1, 0, 0, 0)};

        // Reset values
        #2 rst_n = 1'b0;
        #1;
        chk("reset concesion", 32'(concesion), 32'(0));
        chk("reset valida", 32'(respuesta_valida), 32'(0));
        chk("reset respuesta", 32'(leer()), 32'(0));
        chk("reset id", 32'(id_respuesta), 32'(0));
        chk("reset ocupado", 32'(ocupado), 32'(0));
        aplicarReset();

        // Vector table, one requester at a time
        foreach (tabla[t]) begin
            pend[tabla[t].idx] = 1'b1;
            pa[tabla[t].idx]   = tabla[t].a[3:0];
            pb[tabla[t].idx]   = tabla[t].b[3:0];
            pop[tabla[t].idx]  = tabla[t].op[3:0];
            servicio(0, w, got);
            chk($sformatf("tabla[%0d] respuesta", t), 32'(got), 32'(tabla[t].esp));
        end

        // Back-pressure for 5 cycles while the other requester waits
        pend[0] = 1'b1; pa[0] = 4'd3; pb[0] = 4'd4; pop[0] = 4'd0;
        pend[1] = 1'b1; pa[1] = 4'd6; pb[1] = 4'd2; pop[1] = 4'd1;
        servicio(5, w, got);
        chk("contrapresion respuesta", 32'(got), 32'(refModel(pa[w], pb[w], pop[w])));
        servicio(0, w, got);
        chk("contrapresion segunda", 32'(got), 32'(refModel(pa[w], pb[w], pop[w])));

        // Both requesters continuously asserting, consumer always ready
        aplicarReset();
        pend[0] = 1'b1; pend[1] = 1'b1;
        drive();
        respuesta_lista = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (concesion != 0) begin
                ciclos.push_back(c);
                grants.push_back(int'(concesion));
            end
        end
        respuesta_lista = 1'b0;
        chk("continuo numero de concesiones", 32'(grants.size()), 32'(4));
        if (grants.size() >= 4) begin
            for (int g = 0; g < 4; g++) begin
                chk($sformatf("continuo orden %0d", g), 32'(grants[g]), 32'((g % 2 == 0) ? 1 : 2));
                chk($sformatf("continuo ciclo %0d", g), 32'(ciclos[g]), 32'(3 * g));
            end
        end

        // Randomized traffic against the model
        aplicarReset();
        for (int it = 0; it < 80; it++) begin
            alguno = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(1, 0) == 1) begin
                    pend[i] = 1'b1;
                    pa[i]   = 4'($urandom_range(15, 0));
                    pb[i]   = ($urandom_range(3, 0) == 0) ? 4'd0 : 4'($urandom_range(15, 0));
                    pop[i]  = 4'($urandom_range(15, 0));
                end
                alguno = alguno | pend[i];
            end
            if (!alguno) begin
                pend[it % N] = 1'b1;
                pa[it % N]   = 4'($urandom_range(15, 0));
                pb[it % N]   = 4'($urandom_range(15, 0));
                pop[it % N]  = 4'($urandom_range(9, 0));
            end
            servicio($urandom_range(3, 0), w, got);
            esp = refModel(pa[w], pb[w], pop[w]);
            chk($sformatf("aleatorio %0d op %0d", it, pop[w]), 32'(got), 32'(esp));
        end

        // Reset during EJECUTA abandons the operation and restarts priority
        aplicarReset();
        pend[0] = 1'b1; pa[0] = 4'd3; pb[0] = 4'd4; pop[0] = 4'd0;
        servicio(0, w, got);
        pend[1] = 1'b1; pa[1] = 4'd5; pb[1] = 4'd1; pop[1] = 4'd0;
        drive();
        #1;
        chk("pre-reset concesion", 32'(concesion), 32'(2));
        @(negedge clk);
        pend[1] = 1'b0;
        drive();
        #1 rst_n = 1'b0;
        #1;
        chk("reset en vuelo valida", 32'(respuesta_valida), 32'(0));
        chk("reset en vuelo respuesta", 32'(leer()), 32'(0));
        chk("reset en vuelo id", 32'(id_respuesta), 32'(0));
        chk("reset en vuelo ocupado", 32'(ocupado), 32'(0));
        chk("reset en vuelo concesion", 32'(concesion), 32'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            chk("sin respuesta tras reset", 32'(respuesta_valida), 32'(0));
            chk("libre tras reset", 32'(ocupado), 32'(0));
        end
        pend[0] = 1'b1; pend[1] = 1'b1;
        drive();
        #1;
        chk("prioridad tras reset", 32'(concesion), 32'(1));
        aplicarReset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
